// File: rtl/battleship_pkg.sv
// battleship_pkg: shared types, timing defaults and helpers
// for the battleship key-conditioning input stage.
package battleship_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMING,
        HELD,
        RELEASING
    } btn_state_t;

    localparam int DEBOUNCE_25M      = 250_000;
    localparam int REPEAT_DELAY_25M  = 12_500_000;
    localparam int REPEAT_PERIOD_25M = 5_000_000;

    localparam int N_MOV = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic [N_MOV-1:0] lowest_one(
        input logic [N_MOV-1:0] v
    );
        return v & (~v + 1'b1);
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// debounce_cell: one key -- 2-flop synchroniser, debounce FSM,
// press strobe; optional auto-repeat under AUTOREPEAT_EN.
module debounce_cell
    import battleship_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_25M,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_25M,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_25M,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press,
    output logic level_nxt
);

    // Repeat timing only widens the counters of cells that repeat.
    localparam int CW = $clog2(max3(
        DEBOUNCE_CYCLES,
        REPEAT_EN ? REPEAT_DELAY : 0,
        REPEAT_EN ? REPEAT_PERIOD : 0) + 1);

    localparam logic [CW-1:0] CMAX = '1;
    localparam logic [CW-1:0] DB   = CW'(DEBOUNCE_CYCLES);

    logic          sync1;
    logic          sync2;
    logic          s;
    btn_state_t    state;
    btn_state_t    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] cnt_inc;
    logic          done;
    logic          strobe;
    logic          rep;

    // Synchroniser resets to released so nothing fires out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    assign s       = ~sync2;
    assign cnt_inc = (cnt == CMAX) ? cnt : cnt + 1'b1;
    assign done    = (cnt_inc >= DB);

    // State and debounce counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Debounce transitions; strobe marks the edge that enters HELD.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        strobe    = 1'b0;
        unique case (state)
            IDLE: begin
                if (s) begin
                    state_nxt = ARMING;
                    cnt_nxt   = CW'(1);
                end
            end
            ARMING: begin
                if (!s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (done) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                    strobe    = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            HELD: begin
                if (!s) begin
                    state_nxt = RELEASING;
                    cnt_nxt   = CW'(1);
                end
            end
            RELEASING: begin
                if (s) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (done) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign level_nxt = (state_nxt == HELD) || (state_nxt == RELEASING);

`ifdef AUTOREPEAT_EN
    if (REPEAT_EN) begin : g_rep
        localparam logic [CW-1:0] RD  = CW'(REPEAT_DELAY);
        localparam logic [CW-1:0] RRE = CW'(REPEAT_DELAY - REPEAT_PERIOD);

        logic [CW-1:0] rcnt;
        logic [CW-1:0] rcnt_nxt;
        logic [CW-1:0] rinc;
        logic          rep_c;

        assign rinc = (rcnt == CMAX) ? rcnt : rcnt + 1'b1;

        // Repeat timer; after a repeat it rewinds by one period.
        always_comb begin
            rcnt_nxt = rcnt;
            rep_c    = 1'b0;
            if (state_nxt == HELD && state != HELD) begin
                rcnt_nxt = '0;
            end else if (state == HELD && s) begin
                if (rinc == RD) begin
                    rep_c    = 1'b1;
                    rcnt_nxt = RRE;
                end else begin
                    rcnt_nxt = rinc;
                end
            end
        end

        // Repeat counter register.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rcnt <= '0;
            end else begin
                rcnt <= rcnt_nxt;
            end
        end

        assign rep = rep_c;
    end else begin : g_norep
        assign rep = 1'b0;
    end
`else
    assign rep = 1'b0;
`endif

    assign press = strobe | rep;

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: conditions 4 move keys + confirm into
// debounced levels and strobes; AUTOREPEAT_EN adds move repeat.
module button_conditioner
    import battleship_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_25M,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_25M,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_25M
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_MOV-1:0] mov_n,
    input  logic             confirm_n,
    output logic [N_MOV-1:0] mov_pulse,
    output logic             confirm_pulse,
    output logic [N_MOV-1:0] mov_level,
    output logic             confirm_level
);

    logic [N_MOV-1:0] mov_press;
    logic [N_MOV-1:0] mov_lvl_nxt;
    logic             conf_press;
    logic             conf_lvl_nxt;

    for (genvar i = 0; i < N_MOV; i++) begin : g_mov
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD),
            .REPEAT_EN      (1'b1)
        ) u_cell (
            .clk      (clk),
            .reset    (reset),
            .key_n    (mov_n[i]),
            .press    (mov_press[i]),
            .level_nxt(mov_lvl_nxt[i])
        );
    end

    debounce_cell #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD),
        .REPEAT_EN      (1'b0)
    ) u_confirm (
        .clk      (clk),
        .reset    (reset),
        .key_n    (confirm_n),
        .press    (conf_press),
        .level_nxt(conf_lvl_nxt)
    );

    // Output registers; lowest move index wins, losers are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mov_pulse     <= '0;
            confirm_pulse <= 1'b0;
            mov_level     <= '0;
            confirm_level <= 1'b0;
        end else begin
            mov_pulse     <= lowest_one(mov_press);
            confirm_pulse <= conf_press;
            mov_level     <= mov_lvl_nxt;
            confirm_level <= conf_lvl_nxt;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed scenarios plus random key
// activity against a sliding-window reference model.
module tb_button_conditioner;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] drv = '0;
    logic [3:0] mov_n;
    logic       confirm_n;
    logic [3:0] mov_pulse;
    logic       confirm_pulse;
    logic [3:0] mov_level;
    logic       confirm_level;

    assign mov_n     = ~drv[3:0];
    assign confirm_n = ~drv[4];

    button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mov_n        (mov_n),
        .confirm_n    (confirm_n),
        .mov_pulse    (mov_pulse),
        .confirm_pulse(confirm_pulse),
        .mov_level    (mov_level),
        .confirm_level(confirm_level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: pd = pressed-drive history (bit j = drive j+1 cycles ago).
    logic [15:0] pd [5];
    logic        lv [5];
    int          age [5];
    logic        rawp [5];

    logic [63:0] pmask;
    logic [63:0] cmask;
    logic [63:0] exp6;
    logic [3:0]  pat;
    logic [3:0]  lvl_any;
    int          fall;

    function automatic bit win(input logic [15:0] h, input logic v);
        for (int j = 2; j <= D + 1; j++)
            if (h[j] !== v) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++)
            if (v[i]) return 4'(1 << i);
        return 4'b0000;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 5; k++) begin
            pd[k]   = '0;
            lv[k]   = 1'b0;
            age[k]  = 0;
            rawp[k] = 1'b0;
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < 5; k++) begin
            logic prev;
            logic rose;
            logic s1;
            logic s2;
            logic entry;
            pd[k] = {pd[k][14:0], drv[k]};
            prev  = lv[k];
            rose  = !prev && win(pd[k], 1'b1);
            if (rose) lv[k] = 1'b1;
            else if (prev && win(pd[k], 1'b0)) lv[k] = 1'b0;
            s1    = pd[k][2];
            s2    = pd[k][3];
            entry = rose || (prev && lv[k] && s1 && !s2);
            age[k]  = entry ? 0 : age[k] + 1;
            rawp[k] = rose;
`ifdef AUTOREPEAT_EN
            begin
                logic held;
                held = lv[k] && (rose || s1);
                if (k < 4 && held && !entry && age[k] >= RD &&
                    (age[k] - RD) % RP == 0)
                    rawp[k] = 1'b1;
            end
`endif
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h",
                   tag, cyc, obs, exp);
        end
    endtask

    task automatic check();
        logic [3:0] em;
        logic [3:0] el;
        em = lowest({rawp[3], rawp[2], rawp[1], rawp[0]});
        el = {lv[3], lv[2], lv[1], lv[0]};
        chk("mov_pulse", 64'(mov_pulse), 64'(em));
        chk("confirm_pulse", 64'(confirm_pulse), 64'(rawp[4]));
        chk("mov_level", 64'(mov_level), 64'(el));
        chk("confirm_level", 64'(confirm_level), 64'(lv[4]));
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_update();
        @(negedge clk);
        cyc++;
        check();
    endtask

    task automatic clr();
        pmask   = '0;
        cmask   = '0;
        pat     = '0;
        lvl_any = '0;
        fall    = -1;
    endtask

    task automatic run(input int n);
        for (int i = 1; i <= n; i++) begin
            tick();
            if (mov_pulse != 4'b0000) begin
                pmask[i] = 1'b1;
                pat      = pat | mov_pulse;
            end
            if (confirm_pulse) cmask[i] = 1'b1;
            lvl_any = lvl_any | mov_level;
            if (fall < 0 && !mov_level[0]) fall = i;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_clear();
        check();
    endtask

    initial begin
        model_clear();
        clr();
        repeat (3) tick();
        reset = 1'b1;

        // Reset mid-press, then re-qualification.
        drv = 5'b00001;
        clr();
        run(8);
        chk("t1_first_pulse", pmask, 64'd1 << 6);
        chk("t1_level_held", 64'(mov_level), 64'h1);
        do_reset();
        repeat (3) tick();
        reset = 1'b1;
        clr();
        run(8);
        chk("t1_requal_pulse", pmask, 64'd1 << 6);
        chk("t1_requal_pat", 64'(pat), 64'h1);
        drv = '0;
        run(10);

        // Short bounce, then a clean press on key 1.
        drv = 5'b00010;
        clr();
        run(3);
        drv = '0;
        run(10);
        chk("t2_bounce_pulse", pmask, 64'd0);
        chk("t2_bounce_level", 64'(lvl_any), 64'd0);
        drv = 5'b00010;
        clr();
        run(10);
        chk("t2_press_pulse", pmask, 64'd1 << 6);
        chk("t2_press_pat", 64'(pat), 64'h2);
        drv = '0;
        run(10);

        // Simultaneous presses on keys 1 and 3.
        drv = 5'b01010;
        clr();
        run(10);
        chk("t3_pulse", pmask, 64'd1 << 6);
        chk("t3_pat", 64'(pat), 64'h2);
        drv = '0;
        run(10);

        // Confirm alongside key 3.
        drv = 5'b11000;
        clr();
        run(8);
        chk("t4_mov_pulse", pmask, 64'd1 << 6);
        chk("t4_mov_pat", 64'(pat), 64'h8);
        chk("t4_confirm", cmask, 64'd1 << 6);
        drv = '0;
        run(10);

        // Release bounce keeps level; clean release drops it.
        drv = 5'b00001;
        run(8);
        drv = '0;
        clr();
        run(2);
        drv = 5'b00001;
        run(10);
        chk("t5_bounce_pulse", pmask, 64'd0);
        chk("t5_bounce_fall", 64'(fall), 64'(-1));
        drv = '0;
        clr();
        run(8);
        chk("t5_release_fall", 64'(fall), 64'd6);
        run(4);

        // Long hold on key 2.
`ifdef AUTOREPEAT_EN
        exp6 = (64'd1 << 6) | (64'd1 << 16) | (64'd1 << 19) |
               (64'd1 << 22) | (64'd1 << 25) | (64'd1 << 28);
`else
        exp6 = 64'd1 << 6;
`endif
        drv = 5'b00100;
        clr();
        run(30);
        chk("t6_hold_pulses", pmask, exp6);
        drv = '0;
        run(10);

        // Random key activity, one asynchronous reset inside.
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                do_reset();
                tick();
                tick();
                reset = 1'b1;
            end
            for (int k = 0; k < 5; k++)
                if ($urandom_range(0, 99) < 6) drv[k] = ~drv[k];
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
